// File: rtl/soc_event_dispatch.sv
// Grant-to-event-ID dispatcher: encodes the arbiter's one-hot grant, buffers IDs in a show-ahead FIFO.
// Optional push/stall statistics counters are compiled in with SOC_EVT_DISPATCH_STATS_EN.
module soc_event_dispatch #(
    parameter int  EVNT_NUM   = 256,
    parameter int  FIFO_DEPTH = 8,
    localparam int EVT_ID_W   = $clog2(EVNT_NUM),
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [EVNT_NUM-1:0] grant_i,
    input  logic                any_grant_i,
    output logic                grant_ack_o,
    input  logic                flush_i,
    output logic                evt_valid_o,
    input  logic                evt_ready_i,
    output logic [EVT_ID_W-1:0] evt_data_o,
    output logic [LVL_W-1:0]    fifo_level_o,
    output logic                err_multi_o
`ifdef SOC_EVT_DISPATCH_STATS_EN
    ,
    output logic [31:0]         evt_count_o,
    output logic [15:0]         drop_stall_o
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [EVT_ID_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LVL_W-1:0]    level;
    logic [EVT_ID_W-1:0] enc_id;
    logic                multi_hot;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;

    // Descending scan so the lowest set bit wins.
    always_comb begin
        enc_id = '0;
        for (int i = EVNT_NUM - 1; i >= 0; i--) begin
            if (grant_i[i]) enc_id = EVT_ID_W'(i);
        end
    end

    assign multi_hot = |(grant_i & (grant_i - EVNT_NUM'(1)));

    // full comes from the registered level only, keeping evt_ready_i off the ack path.
    assign full         = (level == LVL_W'(FIFO_DEPTH));
    assign empty        = (level == '0);
    assign grant_ack_o  = any_grant_i & ~full & ~flush_i & ~rst_i;
    assign push         = grant_ack_o;
    assign pop          = ~empty & evt_ready_i & ~flush_i;
    assign evt_valid_o  = ~empty;
    assign evt_data_o   = mem[rd_ptr];
    assign fifo_level_o = level;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc_id;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + LVL_W'(1);
            else if (pop && !push) level <= level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          err_multi_o <= 1'b0;
        else if (multi_hot) err_multi_o <= 1'b1;
    end

`ifdef SOC_EVT_DISPATCH_STATS_EN
    logic [31:0] evt_cnt;
    logic [15:0] stall_cnt;

    // Both counters saturate and ignore flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evt_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (push && evt_cnt != '1)                  evt_cnt   <= evt_cnt + 32'd1;
            if (any_grant_i && full && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign evt_count_o  = evt_cnt;
    assign drop_stall_o = stall_cnt;
`endif

endmodule

// File: tb/tb_soc_event_dispatch.sv
// Randomized self-checking bench for soc_event_dispatch against a queue-based reference model.
module tb_soc_event_dispatch;
    localparam int N = 256;
    localparam int D = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [N-1:0] grant_i;
    logic         any_grant_i;
    logic         grant_ack_o;
    logic         flush_i;
    logic         evt_valid_o;
    logic         evt_ready_i;
    logic [7:0]   evt_data_o;
    logic [3:0]   fifo_level_o;
    logic         err_multi_o;
`ifdef SOC_EVT_DISPATCH_STATS_EN
    logic [31:0]  evt_count_o;
    logic [15:0]  drop_stall_o;
`endif

    soc_event_dispatch dut (
        .clk_i(clk_i), .rst_i(rst_i), .grant_i(grant_i), .any_grant_i(any_grant_i),
        .grant_ack_o(grant_ack_o), .flush_i(flush_i), .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i), .evt_data_o(evt_data_o), .fifo_level_o(fifo_level_o),
        .err_multi_o(err_multi_o)
`ifdef SOC_EVT_DISPATCH_STATS_EN
        , .evt_count_o(evt_count_o), .drop_stall_o(drop_stall_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int     checks = 0;
    int     errors = 0;
    int     q[$];
    bit     m_err;
    longint m_cnt;
    int     m_stall;
    bit     exp_ack;
    bit     exp_pop;

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int lowest(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    // Drive inputs just after a rising edge, predict, then wait for the falling edge to sample.
    task automatic apply(input logic [N-1:0] g, input logic ag, input logic rdy, input logic fl);
        grant_i = g; any_grant_i = ag; evt_ready_i = rdy; flush_i = fl;
        exp_ack = ag && (q.size() < D) && !fl;
        exp_pop = (q.size() > 0) && rdy && !fl;
        @(negedge clk_i);
    endtask

    task automatic tick();
        @(posedge clk_i);
        if ($countones(grant_i) > 1) m_err = 1'b1;
        if (any_grant_i && q.size() == D && m_stall < 65535) m_stall++;
        if (flush_i) q.delete();
        else begin
            if (exp_pop) void'(q.pop_front());
            if (exp_ack) begin
                q.push_back(lowest(grant_i));
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        q.delete(); m_err = 1'b0; m_cnt = 0; m_stall = 0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; grant_i = onehot(5); any_grant_i = 1'b1; flush_i = 1'b0; evt_ready_i = 1'b0;
        model_reset();
        #3;
        checks++; if (grant_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b want 0", grant_ack_o); end
        checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", evt_valid_o); end
        checks++; if (fifo_level_o !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level_o); end
        checks++; if (evt_data_o !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", evt_data_o); end
        checks++; if (err_multi_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err_multi_o); end
        @(negedge clk_i); rst_i = 1'b0; any_grant_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_single();
        apply(onehot(37), 1, 0, 0);
        checks++; if (grant_ack_o !== 1'b1) begin errors++; $display("FAIL single_ack: got %0b want 1", grant_ack_o); end
        tick();
        apply('0, 0, 1, 0);
        checks++; if (evt_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", evt_valid_o); end
        checks++; if (evt_data_o !== 8'd37) begin errors++; $display("FAIL single_data: got %0d want 37", evt_data_o); end
        checks++; if (fifo_level_o !== 4'd1) begin errors++; $display("FAIL single_level: got %0d want 1", fifo_level_o); end
        tick();
        apply('0, 0, 0, 0);
        checks++; if (evt_valid_o !== 1'b0 || fifo_level_o !== 4'd0) begin errors++; $display("FAIL single_drain: got valid=%0b level=%0d want 0/0", evt_valid_o, fifo_level_o); end
        tick();
    endtask

    task automatic test_fill();
        int id = 0;
        int nxt = 0;
        for (int c = 0; c < 40 && (id < 10 || q.size() > 0); c++) begin
            apply(id < 10 ? onehot(id) : '0, id < 10, c >= 10, 0);
            checks++; if (grant_ack_o !== exp_ack) begin errors++; $display("FAIL fill_ack c=%0d: got %0b want %0b", c, grant_ack_o, exp_ack); end
            if (c < 8 || c == 11) begin
                checks++; if (grant_ack_o !== 1'b1) begin errors++; $display("FAIL fill_accept c=%0d: got %0b want 1", c, grant_ack_o); end
            end else if (c < 11) begin
                checks++; if (grant_ack_o !== 1'b0) begin errors++; $display("FAIL fill_hold c=%0d: got %0b want 0", c, grant_ack_o); end
            end
            checks++; if (fifo_level_o !== 4'(q.size())) begin errors++; $display("FAIL fill_level c=%0d: got %0d want %0d", c, fifo_level_o, q.size()); end
            if (exp_pop) begin
                checks++; if (evt_data_o !== 8'(nxt)) begin errors++; $display("FAIL fill_order: got %0d want %0d", evt_data_o, nxt); end
                nxt++;
            end
            tick();
            if (exp_ack) id++;
        end
        checks++; if (nxt !== 10) begin errors++; $display("FAIL fill_count: got %0d want 10", nxt); end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin apply(onehot(100 + k), 1, 0, 0); tick(); end
        for (int k = 0; k < 20; k++) begin
            apply(onehot(104 + k), 1, 1, 0);
            checks++; if (fifo_level_o !== 4'd4 || grant_ack_o !== 1'b1) begin errors++; $display("FAIL stream_level k=%0d: got level=%0d ack=%0b want 4/1", k, fifo_level_o, grant_ack_o); end
            checks++; if (evt_data_o !== 8'(100 + k)) begin errors++; $display("FAIL stream_data k=%0d: got %0d want %0d", k, evt_data_o, 100 + k); end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            apply('0, 0, 1, 0);
            checks++; if (evt_data_o !== 8'(120 + k)) begin errors++; $display("FAIL stream_tail k=%0d: got %0d want %0d", k, evt_data_o, 120 + k); end
            tick();
        end
    endtask

    task automatic test_multi();
        apply(N'(6), 1, 0, 0);
        checks++; if (grant_ack_o !== 1'b1) begin errors++; $display("FAIL multi_ack: got %0b want 1", grant_ack_o); end
        tick();
        apply('0, 0, 0, 0);
        checks++; if (evt_data_o !== 8'd1 || err_multi_o !== 1'b1) begin errors++; $display("FAIL multi_push: got id=%0d err=%0b want 1/1", evt_data_o, err_multi_o); end
        tick();
        apply(onehot(3), 1, 1, 1);
        checks++; if (grant_ack_o !== 1'b0) begin errors++; $display("FAIL flush_ack: got %0b want 0", grant_ack_o); end
        tick();
        apply('0, 0, 0, 0);
        checks++; if (fifo_level_o !== 4'd0 || evt_valid_o !== 1'b0 || err_multi_o !== 1'b1) begin errors++; $display("FAIL flush_state: got level=%0d valid=%0b err=%0b want 0/0/1", fifo_level_o, evt_valid_o, err_multi_o); end
        tick();
        apply(N'(5) << 40, 0, 0, 0);
        checks++; if (grant_ack_o !== 1'b0) begin errors++; $display("FAIL noany_ack: got %0b want 0", grant_ack_o); end
        tick();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 5; k++) begin apply(onehot(10 + k), 1, 0, 0); tick(); end
        apply(onehot(9), 1, 0, 0);
        checks++; if (fifo_level_o !== 4'd5 || grant_ack_o !== 1'b1) begin errors++; $display("FAIL ar_pre: got level=%0d ack=%0b want 5/1", fifo_level_o, grant_ack_o); end
        #1 rst_i = 1'b1;
        #1;
        model_reset();
        checks++; if (evt_valid_o !== 1'b0 || fifo_level_o !== 4'd0 || grant_ack_o !== 1'b0) begin errors++; $display("FAIL ar_drop: got valid=%0b level=%0d ack=%0b want 0/0/0", evt_valid_o, fifo_level_o, grant_ack_o); end
        checks++; if (err_multi_o !== 1'b0 || evt_data_o !== 8'd0) begin errors++; $display("FAIL ar_clear: got err=%0b data=%0d want 0/0", err_multi_o, evt_data_o); end
        @(posedge clk_i); #1 rst_i = 1'b0;
        apply(onehot(255), 1, 0, 0);
        checks++; if (grant_ack_o !== 1'b1) begin errors++; $display("FAIL ar_ack255: got %0b want 1", grant_ack_o); end
        tick();
        apply('0, 0, 1, 0);
        checks++; if (evt_valid_o !== 1'b1 || evt_data_o !== 8'd255 || fifo_level_o !== 4'd1) begin errors++; $display("FAIL ar_out255: got valid=%0b data=%0d level=%0d want 1/255/1", evt_valid_o, evt_data_o, fifo_level_o); end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] g;
        int sel;
        for (int c = 0; c < 400; c++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      g = '0;
            else if (sel == 1) g = onehot(int'($urandom_range(0, 255))) | onehot(int'($urandom_range(0, 255)));
            else               g = onehot(int'($urandom_range(0, 255)));
            apply(g, (g != '0) && ($urandom_range(0, 7) != 0),
                  ((c / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 40) == 0);
            checks++; if (grant_ack_o !== exp_ack) begin errors++; $display("FAIL rnd_ack c=%0d: got %0b want %0b", c, grant_ack_o, exp_ack); end
            checks++; if (fifo_level_o !== 4'(q.size()) || evt_valid_o !== (q.size() != 0)) begin errors++; $display("FAIL rnd_level c=%0d: got %0d/%0b want %0d", c, fifo_level_o, evt_valid_o, q.size()); end
            if (q.size() != 0) begin
                checks++; if (evt_data_o !== 8'(q[0])) begin errors++; $display("FAIL rnd_data c=%0d: got %0d want %0d", c, evt_data_o, q[0]); end
            end
            checks++; if (err_multi_o !== m_err) begin errors++; $display("FAIL rnd_err c=%0d: got %0b want %0b", c, err_multi_o, m_err); end
            tick();
        end
    endtask

`ifdef SOC_EVT_DISPATCH_STATS_EN
    task automatic test_stats();
        apply('0, 0, 0, 0);
        checks++; if (evt_count_o !== 32'(m_cnt) || drop_stall_o !== 16'(m_stall)) begin errors++; $display("FAIL stats_rnd: got %0d/%0d want %0d/%0d", evt_count_o, drop_stall_o, m_cnt, m_stall); end
        tick();
        apply('0, 0, 0, 1); tick();
        dut.evt_cnt = 32'hFFFF_FFFE; m_cnt = 64'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin apply(onehot(k), 1, 1, 0); tick(); end
        apply('0, 0, 0, 0);
        checks++; if (evt_count_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stats_sat: got %0h want ffffffff", evt_count_o); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_multi();
        test_async_reset();
        test_random();
`ifdef SOC_EVT_DISPATCH_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/soc_event_dispatch.md
Name: soc_event_dispatch

Overview:
- Sits directly downstream of the SoC event arbiter.
- Consumes its one-hot grant vector and any-grant flag, and encodes the granted line into a binary event ID.
- Buffers IDs in a small FIFO and presents them on a valid/ready stream to the FC event unit.
- Returns grant_ack to the arbiter only when the ID is actually accepted, so the arbiter's priority rotates only on a successful push.

Parameters:
- EVNT_NUM, 256, number of event lines (width of grant vector)
- EVT_ID_W, $clog2(EVNT_NUM), width of encoded event ID (derived, do not override)
- FIFO_DEPTH, 8, FIFO entries; power of 2, >= 2
- LVL_W, $clog2(FIFO_DEPTH)+1, width of fill-level output (derived)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- grant_i  in  EVNT_NUM  one-hot grant from arbiter
- any_grant_i  in  1  grant_i has a set bit
- grant_ack_o  out  1  grant accepted this cycle (to arbiter)
- flush_i  in  1  synchronous FIFO clear
- evt_valid_o  out  1  head entry valid
- evt_ready_i  in  1  consumer accepts head
- evt_data_o  out  EVT_ID_W  head event ID
- fifo_level_o  out  LVL_W  current occupancy
- err_multi_o  out  1  sticky: multi-hot grant seen

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous and active-high. All state clears immediately on rst_i=1, with no clock required.
- Reset values: FIFO empty, read/write pointers 0, fifo_level_o=0, evt_valid_o=0, evt_data_o=0, err_multi_o=0. grant_ack_o is 0 while rst_i=1.
- Encode (combinational): ID = index of the lowest set bit of grant_i. This value is pushed.
- Accept (combinational): grant_ack_o = any_grant_i & ~full & ~flush_i.
  - Push occurs on the clock edge where grant_ack_o=1.
  - full is derived from registered state only. A pop in the same cycle does not allow a push when full. This gives no combinational path from evt_ready_i to grant_ack_o.
- Output: show-ahead FIFO.
  - evt_valid_o = ~empty; evt_data_o = entry at read pointer.
  - Pop on an edge with evt_valid_o & evt_ready_i & ~flush_i.
- Latency: a grant accepted at edge N is visible on evt_valid_o/evt_data_o after edge N (registered storage). This holds even when the FIFO was empty; there is no bypass.
- Simultaneous push and pop (not full, not empty): level unchanged, both pointers advance.
- Pointers: wrap modulo FIFO_DEPTH. Full/empty use one extra pointer bit (or the level counter). fifo_level_o is in the range 0..FIFO_DEPTH.
- evt_data_o is held stable while evt_valid_o=1 and evt_ready_i=0.
- Flush: while flush_i=1, pointers and level are reset at the next edge. No push and no pop occur. err_multi_o is unaffected.
- Error: err_multi_o is set on any edge where grant_i has more than one bit set, whether or not any_grant_i is asserted. It clears only on reset.
- any_grant_i=0 with grant_i nonzero: no push, no ack; err_multi_o is set if the vector is multi-hot.

Optional Feature:
- Macro: SOC_EVT_DISPATCH_STATS_EN.
- When defined:
  - Adds output evt_count_o [31:0], a saturating count of pushes. It holds at 0xFFFFFFFF once reached.
  - Adds output drop_stall_o [15:0], a saturating count of cycles with any_grant_i=1 and full=1.
  - Both counters clear on rst_i only; flush_i does not affect them.
- When undefined: the ports and logic are absent. Core behaviour is identical in both builds.

Test Plan:
- Reset then idle; grant_i=1<<37, any_grant_i=1 for 1 cycle -> grant_ack_o=1 that cycle; next cycle evt_valid_o=1, evt_data_o=37, fifo_level_o=1; evt_ready_i=1 -> level 0, valid 0.
- evt_ready_i=0; 10 consecutive grants of IDs 0..9 (FIFO_DEPTH=8) -> ack for the first 8 only, level=8, ack=0 for IDs 8,9 (held); then pop one per cycle -> outputs 0..7 in order; the held ID 8 is pushed the cycle after the first pop frees space.
- Level 4, push and pop in the same cycle for 20 cycles with pointer wrap -> level stays 4, output order matches input order, no lost or duplicated IDs.
- grant_i=0x0000_0006 with any_grant_i=1 -> ID 1 pushed, err_multi_o=1 and sticky; flush_i pulse -> level 0, err_multi_o still 1; rst_i -> 0.
- Level 5, assert rst_i asynchronously mid-cycle -> evt_valid_o, fifo_level_o, grant_ack_o drop to 0 immediately; after release, the first grant of ID 255 is pushed and output correctly.
- STATS build: 3 pushes plus 4 stalled-full cycles -> evt_count_o=3, drop_stall_o=4; preload near saturation -> counter holds at max.
